// File: rtl/mux_sel_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mux_arb_pkg
// Description : Shared sizes, FSM state type and helpers for the round-robin
//               arbiter that drives the 4:1 data mux select.
// Contents    : N_REQ  - number of requesters (4)
//               SEL_W  - width of the encoded mux select (2)
//               state_t - arbiter FSM states {IDLE, GRANT}
//               onehot() - index to one-hot grant vector
// Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

   localparam int N_REQ = 4;
   localparam int SEL_W = 2;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      onehot = N_REQ'(1) << idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mux_sel_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : mux_sel_arbiter_if
// Description : Request/grant bundle between the requesters and the arbiter.
// Signals     : req       - request lines, bit i = requester i
//               gnt       - one-hot grant, zero when idle
//               sel_n     - encoded index of current/last owner (mux select)
//               gnt_valid - high while any grant is active
// Modports    : master - requester side (drives req)
//               slave  - arbiter side (drives gnt/sel_n/gnt_valid)
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_sel_arbiter_if;

   logic [mux_arb_pkg::N_REQ-1:0] req;
   logic [mux_arb_pkg::N_REQ-1:0] gnt;
   logic [mux_arb_pkg::SEL_W-1:0] sel_n;
   logic                          gnt_valid;

   modport master (
      output req,
      input  gnt,
      input  sel_n,
      input  gnt_valid
   );

   modport slave (
      input  req,
      output gnt,
      output sel_n,
      output gnt_valid
   );

endinterface
`default_nettype wire

// File: rtl/mux_sel_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick_4
// Description : Combinational round-robin picker. Returns the first set bit
//               of i_cand searching i_start, i_start+1, ... (mod 4).
// Ports       : i_cand  [3:0] - candidate request mask
//               i_start [1:0] - index with highest priority
//               o_found       - any candidate set
//               o_idx   [1:0] - index of the winning candidate
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick_4
   import mux_arb_pkg::*;
(
   input  wire logic [N_REQ-1:0] i_cand,
   input  wire logic [SEL_W-1:0] i_start,
   output logic                  o_found,
   output logic [SEL_W-1:0]      o_idx
);

   logic [N_REQ-1:0] w_rot;
   logic [SEL_W-1:0] w_src;
   logic [SEL_W-1:0] w_off;

   // Rotate so that i_start lands on bit 0; the index arithmetic wraps
   // naturally because N_REQ is exactly 2**SEL_W.
   always_comb begin
      w_rot = '0;
      w_src = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_src    = SEL_W'(i) + i_start;
         w_rot[i] = i_cand[w_src];
      end
   end

   // Fixed priority on the rotated vector: scanning downward lets the lowest
   // set bit be the last (and therefore winning) assignment.
   always_comb begin
      o_found = 1'b0;
      w_off   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            o_found = 1'b1;
            w_off   = SEL_W'(i);
         end
      end
   end

   // Un-rotate back to an absolute requester index.
   assign o_idx = w_off + i_start;

endmodule
`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_sel_arbiter
// Description : Round-robin arbiter in front of the 4:1 data mux. Grants one
//               requester at a time, holds the grant while the owner keeps
//               requesting, and optionally pre-empts after MAX_HOLD cycles
//               when another requester is waiting. All outputs registered.
// Parameters  : MAX_HOLD - max hold cycles under contention (0 = no limit)
//               CNT_W    - hold counter width, 2**CNT_W > MAX_HOLD
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - mux_sel_arbiter_if.slave (req in; gnt, sel_n,
//                       gnt_valid out)
// Revision    : 1.0 - initial release
// ============================================================================
module mux_sel_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   mux_sel_arbiter_if.slave   bus
);

   localparam logic [CNT_W-1:0] c_HOLD_LIM = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

   state_t           r_state,    w_state_nxt;
   logic [N_REQ-1:0] r_gnt,      w_gnt_nxt;
   logic [SEL_W-1:0] r_sel,      w_sel_nxt;
   logic             r_valid,    w_valid_nxt;
   logic [SEL_W-1:0] r_ptr,      w_ptr_nxt;
   logic [CNT_W-1:0] r_hold_cnt, w_cnt_nxt;

   logic [N_REQ-1:0] w_others;
   logic             w_timeout;
   logic             w_release;
   logic [N_REQ-1:0] w_cand;
   logic [SEL_W-1:0] w_start;
   logic             w_found;
   logic [SEL_W-1:0] w_idx;

   // In GRANT, r_sel is the owner index (it always tracks the set gnt bit).
   assign w_others  = bus.req & ~onehot(r_sel);
   assign w_timeout = (MAX_HOLD != 0) && (r_hold_cnt >= c_HOLD_LIM) && (w_others != '0);
   // Owner drop and timeout in the same cycle collapse into a single release.
   assign w_release = (r_state == GRANT) && (!bus.req[r_sel] || w_timeout);

   // The single picker serves both the idle search (from ptr) and the
   // back-to-back regrant (from owner+1, owner masked out so a pre-empted
   // owner goes to the back of the queue).
   assign w_cand  = (r_state == GRANT) ? w_others : bus.req;
   assign w_start = (r_state == GRANT) ? (r_sel + SEL_W'(1)) : r_ptr;

   rr_pick_4 u_pick (
      .i_cand  (w_cand),
      .i_start (w_start),
      .o_found (w_found),
      .o_idx   (w_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_gnt      <= '0;
         r_sel      <= '0;
         r_valid    <= 1'b0;
         r_ptr      <= '0;
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_gnt      <= w_gnt_nxt;
         r_sel      <= w_sel_nxt;
         r_valid    <= w_valid_nxt;
         r_ptr      <= w_ptr_nxt;
         r_hold_cnt <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_sel_nxt   = r_sel;
      w_valid_nxt = r_valid;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_hold_cnt;

      case (r_state)
         IDLE: begin
            // sel_n is left alone while idle so the mux output stays stable.
            if (w_found) begin
               w_state_nxt = GRANT;
               w_gnt_nxt   = onehot(w_idx);
               w_sel_nxt   = w_idx;
               w_valid_nxt = 1'b1;
               w_cnt_nxt   = '0;
            end
         end

         GRANT: begin
            if (w_release) begin
               w_ptr_nxt = r_sel + SEL_W'(1);
               if (w_found) begin
                  w_gnt_nxt   = onehot(w_idx);
                  w_sel_nxt   = w_idx;
                  w_valid_nxt = 1'b1;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = IDLE;
                  w_gnt_nxt   = '0;
                  w_valid_nxt = 1'b0;
               end
            end else if (r_hold_cnt != '1) begin
               w_cnt_nxt = r_hold_cnt + CNT_W'(1);
            end
         end

         default: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   assign bus.gnt       = r_gnt;
   assign bus.sel_n     = r_sel;
   assign bus.gnt_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_sel_arbiter
// Description : Self-checking bench for mux_sel_arbiter. Instance A uses
//               MAX_HOLD=8, instance B uses MAX_HOLD=0 (no timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_sel_arbiter;
   import mux_arb_pkg::*;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   mux_sel_arbiter_if a_if ();
   mux_sel_arbiter_if b_if ();

   mux_sel_arbiter #(.MAX_HOLD(8), .CNT_W(4)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (a_if.slave)
   );

   mux_sel_arbiter #(.MAX_HOLD(0), .CNT_W(4)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] enc(input logic [3:0] g);
      enc = 2'd0;
      for (int i = 0; i < 4; i++) if (g[i]) enc = 2'(i);
   endfunction

   initial begin
      int         wait_c [4];
      int         max_wait;
      logic [3:0] r;
      logic [3:0] g;

      rst_n    = 1'b1;
      a_if.req = '0;
      b_if.req = '0;
      #2 rst_n = 1'b0;
      step(2);

      // Reset state
      chk("rst_gnt",   a_if.gnt,       4'b0000);
      chk("rst_sel",   a_if.sel_n,     2'b00);
      chk("rst_valid", a_if.gnt_valid, 1'b0);
      rst_n = 1'b1;

      // Single request, one-clock latency
      a_if.req = 4'b0100;
      step(1);
      chk("single_gnt",   a_if.gnt,       4'b0100);
      chk("single_sel",   a_if.sel_n,     2'b10);
      chk("single_valid", a_if.gnt_valid, 1'b1);

      // Asynchronous reset mid-grant, well away from a clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_gnt",   a_if.gnt,       4'b0000);
      chk("async_rst_valid", a_if.gnt_valid, 1'b0);
      chk("async_rst_sel",   a_if.sel_n,     2'b00);
      a_if.req = '0;
      step(1);
      rst_n = 1'b1;

      // All requesting: rotate 0,1,2,3,0 with 8 cycles each, no bubble
      a_if.req = 4'b1111;
      step(1);
      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < 8; c++) begin
            chk("rr_gnt",   a_if.gnt,       32'(4'b0001 << (k % 4)));
            chk("rr_valid", a_if.gnt_valid, 1'b1);
            step(1);
         end
      end
      // Now owner 1 just granted; everyone drops
      chk("rr_wrap_gnt", a_if.gnt, 4'b0010);
      a_if.req = 4'b0000;
      step(1);
      chk("drop_valid", a_if.gnt_valid, 1'b0);
      chk("drop_gnt",   a_if.gnt,       4'b0000);
      chk("drop_sel",   a_if.sel_n,     2'b01);

      // Lone owner 1 keeps grant for 20 cycles
      a_if.req = 4'b0010;
      step(1);
      for (int c = 0; c < 20; c++) begin
         chk("alone_gnt", a_if.gnt, 4'b0010);
         step(1);
      end
      a_if.req = 4'b0000;
      step(1);
      chk("alone_rel_valid", a_if.gnt_valid, 1'b0);
      chk("alone_rel_sel",   a_if.sel_n,     2'b01);

      // Owner 3 drops with 0,1,2 waiting: search wraps to start at 0
      a_if.req = 4'b1000;
      step(1);
      chk("own3_gnt", a_if.gnt,   4'b1000);
      chk("own3_sel", a_if.sel_n, 2'b11);
      step(3);
      a_if.req = 4'b0111;
      step(1);
      chk("wrap_gnt",   a_if.gnt,       4'b0001);
      chk("wrap_sel",   a_if.sel_n,     2'b00);
      chk("wrap_valid", a_if.gnt_valid, 1'b1);
      a_if.req = 4'b0000;
      step(1);

      // MAX_HOLD=0: owner 0 is never pre-empted
      b_if.req = 4'b0011;
      step(1);
      chk("nohold_first", b_if.gnt, 4'b0001);
      for (int c = 0; c < 20; c++) begin
         step(1);
         chk("nohold_keep", b_if.gnt, 4'b0001);
      end
      b_if.req = 4'b0010;
      step(1);
      chk("nohold_next_gnt",   b_if.gnt,       4'b0010);
      chk("nohold_next_sel",   b_if.sel_n,     2'b01);
      chk("nohold_next_valid", b_if.gnt_valid, 1'b1);
      b_if.req = 4'b0000;

      // Random traffic: requesters hold req until granted, then drop randomly
      for (int i = 0; i < 4; i++) wait_c[i] = 0;
      max_wait = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         g = a_if.gnt;
         chk("inv_onehot", 32'($onehot0(g)), 1);
         chk("inv_valid",  a_if.gnt_valid, |g);
         if (a_if.gnt_valid) chk("inv_sel", a_if.sel_n, enc(g));
         r = a_if.req;
         for (int i = 0; i < 4; i++) begin
            if (r[i] && !g[i]) wait_c[i]++;
            else               wait_c[i] = 0;
            if (wait_c[i] > max_wait) max_wait = wait_c[i];
            if (r[i] && g[i]) begin
               if ($urandom_range(5) == 0) r[i] = 1'b0;
            end else if (!r[i] && !g[i]) begin
               if ($urandom_range(3) == 0) r[i] = 1'b1;
            end
         end
         a_if.req = r;
         step(1);
      end
      chk("max_wait_le_27", 32'(max_wait <= 27), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
